// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG output path.
//   MCU_DIM / MCU_PIXELS : geometry of one 8x8 MCU (4:4:4 sampling)
//   rgb24_t              : packed {R,G,B} pixel
//   mcu_wr_state_t       : raster writer control states
//   ceil_div8()          : number of MCUs needed to cover a dimension
package jpeg_pkg;

    localparam int MCU_DIM    = 8;
    localparam int MCU_PIXELS = MCU_DIM * MCU_DIM;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mcu_wr_state_t;

    function automatic int ceil_div8(input int n);
        return (n + MCU_DIM - 1) / MCU_DIM;
    endfunction

endpackage

// File: rtl/mcu_addr_gen.sv
// Position tracker for MCU-ordered pixels.
// Walks px/py inside an MCU, then MCUs left-to-right, top-to-bottom, and
// presents the raster address of the current pixel with no multiplier:
// row_base tracks y*WIDTH incrementally, the column is a concatenation.
//   clk, rst_n : clock, async active-low reset
//   clear      : return to pixel (0,0) of MCU (0,0); wins over advance
//   advance    : step to the next pixel in MCU order
//   addr       : y*WIDTH + x of the current pixel, truncated to ADDR_WIDTH
//   in_bounds  : current pixel lies inside the image
//   last       : current pixel is the final pixel of the final MCU
module mcu_addr_gen
    import jpeg_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_bounds,
    output logic                  last
);

    localparam int MCUS_X = ceil_div8(WIDTH);
    localparam int MCUS_Y = ceil_div8(HEIGHT);
    localparam int MXW    = (MCUS_X > 1) ? $clog2(MCUS_X) : 1;
    localparam int MYW    = (MCUS_Y > 1) ? $clog2(MCUS_Y) : 1;
    localparam int XW     = MXW + 3;
    localparam int YW     = MYW + 3;
    // Widest value the address path can reach (padded rows and columns).
    localparam int FULL_W = $clog2(MCUS_Y * MCU_DIM * WIDTH + MCUS_X * MCU_DIM) + 1;
    localparam int AW     = (FULL_W > ADDR_WIDTH) ? FULL_W : ADDR_WIDTH;

    localparam logic [AW-1:0]   ROW_STEP     = AW'(WIDTH);
    localparam logic [AW-1:0]   MCU_ROW_STEP = AW'(WIDTH * MCU_DIM);
    localparam logic [MXW-1:0]  MX_LAST      = MXW'(MCUS_X - 1);
    localparam logic [MYW-1:0]  MY_LAST      = MYW'(MCUS_Y - 1);
    localparam logic [XW:0]     X_LIM        = (XW + 1)'(WIDTH);
    localparam logic [YW:0]     Y_LIM        = (YW + 1)'(HEIGHT);

    logic [2:0]     px, py;
    logic [MXW-1:0] mcu_x;
    logic [MYW-1:0] mcu_y;
    logic [AW-1:0]  mcu_row_base;   // mcu_y*8*WIDTH
    logic [AW-1:0]  row_base;       // (mcu_y*8 + py)*WIDTH

    logic          px_wrap, py_wrap, mx_wrap;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] addr_full;

    assign px_wrap = (px == 3'd7);
    assign py_wrap = (py == 3'd7);
    assign mx_wrap = (mcu_x == MX_LAST);

    // MCU size is a power of two, so coordinates are plain concatenations.
    assign x = {mcu_x, px};
    assign y = {mcu_y, py};

    assign addr_full = row_base + AW'(x);
    assign addr      = addr_full[ADDR_WIDTH-1:0];
    assign in_bounds = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign last      = px_wrap && py_wrap && mx_wrap && (mcu_y == MY_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px           <= '0;
            py           <= '0;
            mcu_x        <= '0;
            mcu_y        <= '0;
            mcu_row_base <= '0;
            row_base     <= '0;
        end else if (clear) begin
            px           <= '0;
            py           <= '0;
            mcu_x        <= '0;
            mcu_y        <= '0;
            mcu_row_base <= '0;
            row_base     <= '0;
        end else if (advance) begin
            px <= px + 3'd1;
            if (px_wrap) begin
                py <= py + 3'd1;
                if (!py_wrap) begin
                    row_base <= row_base + ROW_STEP;
                end else if (!mx_wrap) begin
                    // Next MCU to the right starts back at the top row.
                    mcu_x    <= mcu_x + MXW'(1);
                    row_base <= mcu_row_base;
                end else begin
                    // Next MCU row. After the final MCU mcu_y may run past
                    // MCUS_Y-1; that is harmless since a clear precedes reuse.
                    mcu_x        <= '0;
                    mcu_y        <= mcu_y + MYW'(1);
                    mcu_row_base <= mcu_row_base + MCU_ROW_STEP;
                    row_base     <= mcu_row_base + MCU_ROW_STEP;
                end
            end
        end
    end

endmodule

// File: rtl/jpeg_mcu_raster_writer.sv
// Converts an MCU-ordered RGB pixel stream into raster frame-buffer writes.
//   clk, rst_n  : clock (frame-buffer write domain), async active-low reset
//   start       : pulse in IDLE to arm a new frame
//   busy        : frame in progress (RUN state)
//   frame_done  : one-cycle pulse alongside the final pixel's write slot
//   in_valid/in_ready/in_data : pixel stream, {R,G,B}
//   wr_en/wr_addr/wr_data     : frame-buffer write port, one cycle after
//                               each transfer; clipped pixels give wr_en=0
module jpeg_mcu_raster_writer
    import jpeg_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [23:0]           in_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [23:0]           wr_data
);

    mcu_wr_state_t state, state_nxt;

    logic                  xfer;
    logic                  clear;
    logic [ADDR_WIDTH-1:0] ag_addr;
    logic                  ag_in_bounds;
    logic                  ag_last;
    rgb24_t                pix_q;

    assign xfer = in_valid && in_ready;

    mcu_addr_gen #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .advance   (xfer),
        .addr      (ag_addr),
        .in_bounds (ag_in_bounds),
        .last      (ag_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // in_ready depends on state only so the upstream handshake has no
    // combinational loop back through in_valid.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && ag_last) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write port: address and data follow every transfer (clipped or not),
    // the strobe only fires for in-image pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            pix_q   <= '0;
        end else begin
            wr_en <= xfer && ag_in_bounds;
            if (xfer) begin
                wr_addr <= ag_addr;
                pix_q   <= in_data;
            end
        end
    end

    assign wr_data = pix_q;

endmodule

// File: tb/tb_jpeg_mcu_raster_writer.sv
module tb_jpeg_mcu_raster_writer;

    logic        clk;
    logic        rst_n;
    logic        start_s    [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic        in_valid_s [2];
    logic        in_ready_s [2];
    logic [23:0] in_data_s  [2];
    logic        wr_en_s    [2];
    logic [18:0] wr_addr_s  [2];
    logic [23:0] wr_data_s  [2];

    int W [2] = '{16, 12};
    int H [2] = '{16, 10};

    int nchecks = 0;
    int nerr    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d0: square image, no clipping; d1: clipped right and bottom edges.
    jpeg_mcu_raster_writer #(.WIDTH(16), .HEIGHT(16), .ADDR_WIDTH(19)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]),
        .frame_done(done_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_data(in_data_s[0]), .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]),
        .wr_data(wr_data_s[0]));

    jpeg_mcu_raster_writer #(.WIDTH(12), .HEIGHT(10), .ADDR_WIDTH(19)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]),
        .frame_done(done_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_data(in_data_s[1]), .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]),
        .wr_data(wr_data_s[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int d, input string tag);
        check($sformatf("d%0d_%s_busy", d, tag), 32'(busy_s[d]), 32'd0);
        check($sformatf("d%0d_%s_done", d, tag), 32'(done_s[d]), 32'd0);
        check($sformatf("d%0d_%s_wr_en", d, tag), 32'(wr_en_s[d]), 32'd0);
        check($sformatf("d%0d_%s_in_ready", d, tag), 32'(in_ready_s[d]), 32'd0);
    endtask

    // Streams one frame into DUT d. The reference maps the stream index k to
    // image coordinates directly: MCU number k/64, raster within the MCU k%64.
    task automatic run_frame(input int d, input int vprob, input bit rnd_data,
                             input int abort_at, input bit mid_start);
        int          mcus_x, total, k, cycles, writes, exp_writes;
        int          mcu, r, x, y;
        bit          v, ew, pulsed;
        logic [23:0] dat;
        mcus_x     = (W[d] + 7) / 8;
        total      = mcus_x * ((H[d] + 7) / 8) * 64;
        k          = 0;
        cycles     = 0;
        writes     = 0;
        exp_writes = 0;
        pulsed     = 1'b0;

        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        check($sformatf("d%0d_busy_after_start", d), 32'(busy_s[d]), 32'd1);

        while (k < total && cycles < 20000) begin
            if (abort_at > 0 && k == abort_at) break;
            v   = ($urandom_range(99) < vprob);
            dat = rnd_data ? 24'($urandom) : 24'(k);
            in_valid_s[d] = v;
            in_data_s[d]  = dat;
            if (mid_start && k == 37 && !pulsed) begin
                start_s[d] = 1'b1;
                pulsed     = 1'b1;
            end
            check($sformatf("d%0d_in_ready_run k=%0d", d, k), 32'(in_ready_s[d]), 32'd1);
            @(posedge clk); #1;
            start_s[d] = 1'b0;
            cycles++;
            if (v) begin
                mcu = k / 64;
                r   = k % 64;
                x   = (mcu % mcus_x) * 8 + r % 8;
                y   = (mcu / mcus_x) * 8 + r / 8;
                ew  = (x < W[d]) && (y < H[d]);
                check($sformatf("d%0d_wr_en k=%0d", d, k), 32'(wr_en_s[d]), 32'(ew));
                if (ew) begin
                    check($sformatf("d%0d_wr_addr k=%0d", d, k), 32'(wr_addr_s[d]), 32'(y * W[d] + x));
                    check($sformatf("d%0d_wr_data k=%0d", d, k), 32'(wr_data_s[d]), 32'(dat));
                    exp_writes++;
                end
                if (wr_en_s[d] === 1'b1) writes++;
                check($sformatf("d%0d_frame_done k=%0d", d, k), 32'(done_s[d]), 32'(k == total - 1));
                check($sformatf("d%0d_busy k=%0d", d, k), 32'(busy_s[d]), 32'(k != total - 1));
                k++;
            end else begin
                check($sformatf("d%0d_stall_wr_en k=%0d", d, k), 32'(wr_en_s[d]), 32'd0);
                check($sformatf("d%0d_stall_done k=%0d", d, k), 32'(done_s[d]), 32'd0);
            end
        end
        in_valid_s[d] = 1'b0;

        if (abort_at > 0) begin
            check($sformatf("d%0d_abort_reached", d), 32'(k), 32'(abort_at));
            rst_n = 1'b0;
            #2;
            check_quiet(d, "in_reset");
            check($sformatf("d%0d_reset_wr_addr", d), 32'(wr_addr_s[d]), 32'd0);
            @(posedge clk); #2;
            rst_n = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
                check_quiet(d, "after_abort");
            end
            return;
        end

        check($sformatf("d%0d_all_accepted", d), 32'(k), 32'(total));
        check($sformatf("d%0d_write_count", d), 32'(writes), 32'(exp_writes));
        check($sformatf("d%0d_write_count_area", d), 32'(writes), 32'(W[d] * H[d]));
        check($sformatf("d%0d_in_ready_done", d), 32'(in_ready_s[d]), 32'd0);
        @(posedge clk); #1;
        check_quiet(d, "post_frame");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]    = 1'b0;
            in_valid_s[i] = 1'b0;
            in_data_s[i]  = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check_quiet(i, "reset");
            check($sformatf("d%0d_reset_wr_addr", i), 32'(wr_addr_s[i]), 32'd0);
            check($sformatf("d%0d_reset_wr_data", i), 32'(wr_data_s[i]), 32'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pixels offered while idle are ignored.
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 24'hABCDEF;
        repeat (20) begin
            @(posedge clk); #1;
            check("d0_idle_in_ready", 32'(in_ready_s[0]), 32'd0);
            check("d0_idle_wr_en", 32'(wr_en_s[0]), 32'd0);
        end
        in_valid_s[0] = 1'b0;

        run_frame(0, 100, 1'b0, 0, 1'b0);   // 16x16, index data
        run_frame(0, 100, 1'b0, 0, 1'b1);   // stray start mid-frame
        run_frame(0, 50,  1'b1, 0, 1'b0);   // random stalls, random data
        run_frame(1, 100, 1'b0, 0, 1'b0);   // 12x10 clipping
        run_frame(1, 60,  1'b1, 0, 1'b1);   // clipping with stalls
        run_frame(0, 100, 1'b0, 100, 1'b0); // abort after 100 transfers
        run_frame(0, 80,  1'b1, 0, 1'b0);   // fresh frame restarts at addr 0

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/jpeg_mcu_raster_writer.md
Name: jpeg_mcu_raster_writer

Overview:
- Sits between the JPEG decoder's colour-conversion output and the dual-port frame buffer write port.
- Accepts decoded 24-bit RGB pixels in 8x8 MCU order over a valid/ready stream: pixels row-major inside each MCU, MCUs left-to-right then top-to-bottom (4:4:4 sampling).
- Converts each pixel's position into a raster frame-buffer address and issues single-cycle write strobes.
- Clips pixels beyond the image edge and signals end of frame.

Parameters:
- WIDTH, 640, image width in pixels (1..4096).
- HEIGHT, 480, image height in pixels (1..4096).
- ADDR_WIDTH, 19, frame-buffer address width; must satisfy 2**ADDR_WIDTH >= WIDTH*HEIGHT.

Ports:
- clk  input  1  single clock; same domain as the frame buffer write clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that arms the block for a new frame.
- busy  output  1  high from the cycle after an accepted start until the cycle frame_done is asserted.
- frame_done  output  1  one-cycle pulse, coincident with the write of the last MCU pixel.
- in_valid  input  1  decoder pixel valid.
- in_ready  output  1  block can accept a pixel.
- in_data  input  24  {R,G,B}, 8 bits each.
- wr_en  output  1  frame buffer write strobe.
- wr_addr  output  ADDR_WIDTH  raster address, y*WIDTH + x.
- wr_data  output  24  pixel data, passed through unchanged.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all counters = 0.
  - busy, frame_done, wr_en and in_ready = 0; wr_addr = 0; wr_data = 0.
- Derived constants: MCUS_X = ceil(WIDTH/8); MCUS_Y = ceil(HEIGHT/8).
- State machine:
  - IDLE: in_ready = 0. start = 1 moves to RUN and clears px, py, mcu_x and mcu_y.
  - RUN: in_ready = 1, combinational from state only, never dependent on in_valid. A transfer occurs when in_valid and in_ready are both 1.
  - DONE: lasts one cycle. frame_done = 1, then the state returns to IDLE.
  - A start pulse during RUN or DONE is ignored.
- Counter order on each transfer:
  - px increments 0..7.
  - When px wraps, py increments 0..7.
  - When py wraps, mcu_x increments 0..MCUS_X-1.
  - When mcu_x wraps, mcu_y increments.
- Coordinates: x = mcu_x*8 + px; y = mcu_y*8 + py.
- Write timing (one-cycle latency):
  - The cycle after a transfer: wr_en = (x < WIDTH && y < HEIGHT); wr_addr = y*WIDTH + x, truncated to ADDR_WIDTH; wr_data = in_data as sampled.
  - With no transfer, wr_en = 0 next cycle. wr_addr and wr_data hold their last values.
- Arithmetic: the address is generated incrementally (row base plus column offset), with no runtime multiplier. Internal counters are sized for x up to MCUS_X*8-1 and y up to MCUS_Y*8-1 without overflow.
- Clipping: partial edge MCUs are still consumed in full (all 64 pixels accepted). Out-of-image pixels produce wr_en = 0 in their write cycle.
- Last pixel: the transfer at mcu_x = MCUS_X-1, mcu_y = MCUS_Y-1, px = 7, py = 7 moves the state to DONE.
  - frame_done pulses in the following cycle, together with that pixel's write strobe (the strobe is suppressed if the pixel is clipped).
  - busy drops in the same cycle.
  - in_ready = 0 from the DONE cycle onward.
- Stalls: in_valid may drop for any number of cycles mid-frame. Counters hold and no write is issued.
- Reset mid-frame: the block returns to IDLE immediately. There is no frame_done, the partial frame is abandoned, and the next start begins again at address 0.

Decomposition:
- Shared package jpeg_pkg:
  - MCU_DIM = 8 and MCU_PIXELS = 64.
  - Typedef rgb24_t for packed {R,G,B}.
  - State enum mcu_wr_state_t with values IDLE, RUN, DONE.
- Sub-module: mcu_addr_gen. It holds the px/py/mcu_x/mcu_y counters, the incremental row-base/address logic and the in-bounds flag. It is driven by an advance strobe and a clear strobe. The top level owns the FSM, the handshake and the output registers.

Test Plan:
1. WIDTH=16, HEIGHT=16: start, then stream 256 pixels with in_data = index -> writes at pixel 0 -> addr 0; pixel 8 -> addr 16; pixel 64 -> addr 8; pixel 128 -> addr 128; pixel 255 -> addr 255 with frame_done = 1 in the same cycle; exactly 256 wr_en pulses.
2. WIDTH=12, HEIGHT=10: stream 256 pixels -> all 256 accepted, exactly 120 wr_en pulses; MCU 1 pixel px=4, py=0 (x=12) produces no write; the last write is at addr 119; frame_done follows the 256th transfer.
3. Pattern 1 with in_valid randomly deasserted about 50% of cycles -> identical address/data sequence; no writes in stall cycles; in_ready stays 1 throughout RUN.
4. in_valid high in IDLE with no start -> in_ready = 0 and no writes for 20 cycles. A start pulse issued mid-frame -> counters unaffected and the frame completes normally.
5. rst_n asserted after 100 transfers, released, start reissued -> no frame_done from the aborted frame; the first write of the new frame is at addr 0.
6. Default 640x480: full frame -> 307200 writes; final write at addr 307199 with frame_done; busy = 0 the cycle after.
